// File: rtl/logic_issue_stage_pkg.sv
// logic_issue_stage_pkg: shared constants, opcode encodings and helpers for the logical-unit issue stage
package logic_issue_stage_pkg;

    localparam int WORD_SIZE   = 19;
    localparam int NUM_REGS    = 16;
    localparam int REG_ADDR_W  = 4;
    localparam int OPCODE_W    = 5;
    localparam int STALL_CNT_W = 16;

    localparam int OPC_LSB = 14;
    localparam int RD_LSB  = 10;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 2;

    typedef enum logic [OPCODE_W-1:0] {
        OP_AND = 5'h08,
        OP_OR  = 5'h09,
        OP_XOR = 5'h0A,
        OP_NOT = 5'h0B
    } opcode_e;

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } out_state_e;

    function automatic logic is_logical(input logic [OPCODE_W-1:0] op);
        return op inside {OP_AND, OP_OR, OP_XOR, OP_NOT};
    endfunction

endpackage

// File: rtl/logic_issue_stage_reg_scoreboard.sv
// logic_issue_stage_reg_scoreboard: per-register busy tracking with writeback-aware hazard checks
//   clk, rst_n            clock, async active-low reset
//   set_en, set_idx       mark a destination busy on issue
//   clr_en, clr_idx       clear a register on writeback
//   rs1, rs2, rd          indices to check
//   rs1_busy, rs2_busy,
//   rd_busy               busy after same-cycle writeback clearing
module logic_issue_stage_reg_scoreboard
    import logic_issue_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_idx,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_idx,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rd_busy
);

    logic [NUM_REGS-1:0] busy, live, set_mask, clr_mask;

    assign set_mask = set_en ? (NUM_REGS'(1) << set_idx) : '0;
    assign clr_mask = clr_en ? (NUM_REGS'(1) << clr_idx) : '0;
    // A register being written back this cycle is already free for checks.
    assign live     = busy & ~clr_mask;
    assign rs1_busy = live[rs1];
    assign rs2_busy = live[rs2];
    assign rd_busy  = live[rd];

    // OR-ing the set mask last makes a same-index set win over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= live | set_mask;
    end

endmodule

// File: rtl/logic_issue_stage.sv
// logic_issue_stage: decode, operand fetch with bypass and hazard-stalled issue into the logical unit
//   in_valid/in_ready/in_instr       instruction handshake
//   rf_raddr*/rf_rdata*              combinational register file reads
//   wb_valid/wb_rd/wb_data           logical-unit writeback (bypass + scoreboard clear)
//   out_valid/out_ready/out_*        registered issue bundle
//   illegal_op                       one-cycle pulse when a non-logical opcode is dropped
//   stall_count                      saturating hazard-stall cycle counter
module logic_issue_stage
    import logic_issue_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_SIZE-1:0]   in_instr,
    output logic [REG_ADDR_W-1:0]  rf_raddr1,
    input  logic [WORD_SIZE-1:0]   rf_rdata1,
    output logic [REG_ADDR_W-1:0]  rf_raddr2,
    input  logic [WORD_SIZE-1:0]   rf_rdata2,
    input  logic                   wb_valid,
    input  logic [REG_ADDR_W-1:0]  wb_rd,
    input  logic [WORD_SIZE-1:0]   wb_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OPCODE_W-1:0]    out_opcode,
    output logic [WORD_SIZE-1:0]   out_operand_1,
    output logic [WORD_SIZE-1:0]   out_operand_2,
    output logic [REG_ADDR_W-1:0]  out_rd,
    output logic                   illegal_op,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic [OPCODE_W-1:0]   opcode;
    logic [REG_ADDR_W-1:0] rd, rs1, rs2;
    logic                  legal, is_not, hazard;
    logic                  in_fire, legal_fire, illegal_fire;
    logic                  rs1_busy, rs2_busy, rd_busy;
    logic [WORD_SIZE-1:0]  op1, op2;
    logic                  unused_reserved;
    out_state_e            state_q, state_d;

    assign opcode          = in_instr[OPC_LSB +: OPCODE_W];
    assign rd              = in_instr[RD_LSB +: REG_ADDR_W];
    assign rs1             = in_instr[RS1_LSB +: REG_ADDR_W];
    assign rs2             = in_instr[RS2_LSB +: REG_ADDR_W];
    assign unused_reserved = ^in_instr[RS2_LSB-1:0];
    assign rf_raddr1       = rs1;
    assign rf_raddr2       = rs2;

    assign legal  = is_logical(opcode);
    assign is_not = opcode == OP_NOT;

    logic_issue_stage_reg_scoreboard u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (legal_fire),
        .set_idx  (rd),
        .clr_en   (wb_valid),
        .clr_idx  (wb_rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy)
    );

    // NOT has no second source, so rs2 never blocks it.
    assign hazard       = in_valid & legal & (rs1_busy | (rs2_busy & ~is_not) | rd_busy);
    assign out_valid    = state_q == ST_FULL;
    assign in_ready     = (~out_valid | out_ready) & ~hazard;
    assign in_fire      = in_valid & in_ready;
    assign legal_fire   = in_fire & legal;
    assign illegal_fire = in_fire & ~legal;

    assign op1 = (wb_valid && wb_rd == rs1) ? wb_data : rf_rdata1;
    assign op2 = is_not ? '0 : (wb_valid && wb_rd == rs2) ? wb_data : rf_rdata2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    // Ready is only granted when empty or draining, so a fire always lands in FULL.
    always_comb begin
        state_d = state_q;
        if (legal_fire)     state_d = ST_FULL;
        else if (out_ready) state_d = ST_EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_opcode    <= '0;
            out_operand_1 <= '0;
            out_operand_2 <= '0;
            out_rd        <= '0;
            illegal_op    <= 1'b0;
            stall_count   <= '0;
        end else begin
            if (legal_fire) begin
                out_opcode    <= opcode;
                out_operand_1 <= op1;
                out_operand_2 <= op2;
                out_rd        <= rd;
            end
            illegal_op <= illegal_fire;
            if (hazard && !(&stall_count)) stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_logic_issue_stage.sv
// tb_logic_issue_stage: directed self-checking bench for logic_issue_stage
module tb_logic_issue_stage;
    import logic_issue_stage_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [WORD_SIZE-1:0]   in_instr;
    logic [REG_ADDR_W-1:0]  rf_raddr1, rf_raddr2;
    logic [WORD_SIZE-1:0]   rf_rdata1, rf_rdata2;
    logic                   wb_valid;
    logic [REG_ADDR_W-1:0]  wb_rd;
    logic [WORD_SIZE-1:0]   wb_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [OPCODE_W-1:0]    out_opcode;
    logic [WORD_SIZE-1:0]   out_operand_1, out_operand_2;
    logic [REG_ADDR_W-1:0]  out_rd;
    logic                   illegal_op;
    logic [STALL_CNT_W-1:0] stall_count;

    int compared = 0;
    int mismatched = 0;

    logic_issue_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .rf_raddr1     (rf_raddr1),
        .rf_rdata1     (rf_rdata1),
        .rf_raddr2     (rf_raddr2),
        .rf_rdata2     (rf_rdata2),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_opcode    (out_opcode),
        .out_operand_1 (out_operand_1),
        .out_operand_2 (out_operand_2),
        .out_rd        (out_rd),
        .illegal_op    (illegal_op),
        .stall_count   (stall_count)
    );

    always #5 clk = ~clk;

    function automatic logic [WORD_SIZE-1:0] mk(input logic [4:0] op, input logic [3:0] d, input logic [3:0] s1, input logic [3:0] s2);
        return {op, d, s1, s2, 2'b00};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [WORD_SIZE-1:0] ins, input logic [WORD_SIZE-1:0] d1,
                       input logic [WORD_SIZE-1:0] d2, input logic wv, input logic [3:0] wr,
                       input logic [WORD_SIZE-1:0] wd, input logic ordy);
        in_valid  = v;
        in_instr  = ins;
        rf_rdata1 = d1;
        rf_rdata2 = d2;
        wb_valid  = wv;
        wb_rd     = wr;
        wb_data   = wd;
        out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drv(0, '0, '0, '0, 0, 4'd0, '0, 0);
        #11;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_illegal", 32'(illegal_op), 32'd0);
        chk("rst_stall", 32'(stall_count), 32'd0);
        chk("rst_opcode", 32'(out_opcode), 32'd0);
        chk("rst_rd", 32'(out_rd), 32'd0);
        rst_n = 1'b1;
        tick();

        // AND r3 = r1 & r2
        drv(1, mk(5'h08, 4'd3, 4'd1, 4'd2), 19'h7_0F0F, 19'h0_FFFF, 0, 4'd0, '0, 1);
        chk("and_raddr1", 32'(rf_raddr1), 32'd1);
        chk("and_raddr2", 32'(rf_raddr2), 32'd2);
        chk("and_ready", 32'(in_ready), 32'd1);
        tick();
        chk("and_valid", 32'(out_valid), 32'd1);
        chk("and_opcode", 32'(out_opcode), 32'h08);
        chk("and_op1", 32'(out_operand_1), 32'h7_0F0F);
        chk("and_op2", 32'(out_operand_2), 32'h0_FFFF);
        chk("and_rd", 32'(out_rd), 32'd3);

        // RAW on r3: stall, then resolve through same-cycle writeback bypass
        drv(1, mk(5'h0A, 4'd4, 4'd3, 4'd1), 19'h0_0000, 19'h0_0055, 0, 4'd0, '0, 1);
        chk("raw_ready0", 32'(in_ready), 32'd0);
        tick();
        chk("raw_drained", 32'(out_valid), 32'd0);
        chk("raw_stall1", 32'(stall_count), 32'd1);
        chk("raw_ready1", 32'(in_ready), 32'd0);
        tick();
        chk("raw_stall2", 32'(stall_count), 32'd2);
        drv(1, mk(5'h0A, 4'd4, 4'd3, 4'd1), 19'h0_0000, 19'h0_0055, 1, 4'd3, 19'h1_2345, 1);
        chk("bypass_ready", 32'(in_ready), 32'd1);
        tick();
        chk("xor_valid", 32'(out_valid), 32'd1);
        chk("xor_opcode", 32'(out_opcode), 32'h0A);
        chk("xor_op1_bypass", 32'(out_operand_1), 32'h1_2345);
        chk("xor_op2", 32'(out_operand_2), 32'h0_0055);
        chk("xor_rd", 32'(out_rd), 32'd4);
        chk("xor_stall_held", 32'(stall_count), 32'd2);

        // OR r7 = r8 | r9 issued back-to-back, then held under backpressure
        drv(1, mk(5'h09, 4'd7, 4'd8, 4'd9), 19'h0_000A, 19'h0_000B, 0, 4'd0, '0, 1);
        chk("or_ready", 32'(in_ready), 32'd1);
        tick();
        chk("or_opcode", 32'(out_opcode), 32'h09);
        chk("or_rd", 32'(out_rd), 32'd7);
        drv(1, mk(5'h08, 4'd10, 4'd11, 4'd12), 19'h0_00F0, 19'h0_0F00, 0, 4'd0, '0, 0);
        chk("bp_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_opcode", 32'(out_opcode), 32'h09);
            chk("bp_rd", 32'(out_rd), 32'd7);
            chk("bp_op1", 32'(out_operand_1), 32'h0_000A);
            chk("bp_op2", 32'(out_operand_2), 32'h0_000B);
            chk("bp_ready_hold", 32'(in_ready), 32'd0);
        end
        drv(1, mk(5'h08, 4'd10, 4'd11, 4'd12), 19'h0_00F0, 19'h0_0F00, 0, 4'd0, '0, 1);
        chk("b2b_ready", 32'(in_ready), 32'd1);
        tick();
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_opcode", 32'(out_opcode), 32'h08);
        chk("b2b_rd", 32'(out_rd), 32'd10);
        chk("b2b_op1", 32'(out_operand_1), 32'h0_00F0);
        chk("b2b_op2", 32'(out_operand_2), 32'h0_0F00);
        chk("b2b_stall", 32'(stall_count), 32'd2);

        // r4 still busy from the XOR issue
        drv(1, mk(5'h0A, 4'd1, 4'd4, 4'd0), '0, '0, 0, 4'd0, '0, 1);
        chk("busy4_ready", 32'(in_ready), 32'd0);
        drv(0, '0, '0, '0, 0, 4'd0, '0, 1);
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Illegal opcode on busy registers: consumed without stalling
        drv(1, mk(5'h01, 4'd4, 4'd7, 4'd4), '0, '0, 0, 4'd0, '0, 0);
        chk("ill_ready", 32'(in_ready), 32'd1);
        tick();
        chk("ill_pulse", 32'(illegal_op), 32'd1);
        chk("ill_valid", 32'(out_valid), 32'd0);
        drv(0, '0, '0, '0, 0, 4'd0, '0, 0);
        tick();
        chk("ill_pulse_end", 32'(illegal_op), 32'd0);
        drv(1, mk(5'h08, 4'd1, 4'd7, 4'd0), '0, '0, 0, 4'd0, '0, 0);
        chk("ill_busy_kept", 32'(in_ready), 32'd0);

        // OR r6 = r0 | r0 makes r6 busy
        drv(1, mk(5'h09, 4'd6, 4'd0, 4'd0), '0, '0, 0, 4'd0, '0, 1);
        chk("r6_ready", 32'(in_ready), 32'd1);
        tick();
        chk("r6_rd", 32'(out_rd), 32'd6);

        // NOT r5 = ~r5 with rs2 field on busy r6: no stall, operand 2 forced to zero
        drv(1, mk(5'h0B, 4'd5, 4'd5, 4'd6), 19'h2_AAAA, 19'h7_7777, 0, 4'd0, '0, 1);
        chk("not_ready", 32'(in_ready), 32'd1);
        tick();
        chk("not_opcode", 32'(out_opcode), 32'h0B);
        chk("not_op1", 32'(out_operand_1), 32'h2_AAAA);
        chk("not_op2", 32'(out_operand_2), 32'd0);
        chk("not_rd", 32'(out_rd), 32'd5);

        // WAW on r5 until its writeback
        drv(1, mk(5'h08, 4'd5, 4'd0, 4'd1), 19'h0_0001, 19'h0_0002, 0, 4'd0, '0, 1);
        chk("waw_ready", 32'(in_ready), 32'd0);
        tick();
        chk("waw_stall", 32'(stall_count), 32'd3);
        chk("waw_drained", 32'(out_valid), 32'd0);
        drv(1, mk(5'h08, 4'd5, 4'd0, 4'd1), 19'h0_0001, 19'h0_0002, 1, 4'd5, 19'h0_0000, 1);
        chk("waw_wb_ready", 32'(in_ready), 32'd1);
        tick();
        chk("waw_valid", 32'(out_valid), 32'd1);
        chk("waw_rd", 32'(out_rd), 32'd5);
        chk("waw_op1", 32'(out_operand_1), 32'h0_0001);
        chk("waw_op2", 32'(out_operand_2), 32'h0_0002);

        // Async reset while holding a bundle with busy registers
        drv(0, '0, '0, '0, 0, 4'd0, '0, 0);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_stall", 32'(stall_count), 32'd0);
        chk("mrst_rd", 32'(out_rd), 32'd0);
        chk("mrst_opcode", 32'(out_opcode), 32'd0);
        #1;
        rst_n = 1'b1;
        drv(1, mk(5'h08, 4'd4, 4'd4, 4'd7), 19'h0_1111, 19'h0_2222, 0, 4'd0, '0, 1);
        chk("post_ready", 32'(in_ready), 32'd1);
        tick();
        chk("post_valid", 32'(out_valid), 32'd1);
        chk("post_rd", 32'(out_rd), 32'd4);
        chk("post_op1", 32'(out_operand_1), 32'h0_1111);
        chk("post_op2", 32'(out_operand_2), 32'h0_2222);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/logic_issue_stage.md
Name: logic_issue_stage

Overview:
- Issue stage directly upstream of the logical unit.
- Accepts 19-bit instructions over a valid/ready handshake, decodes AND/OR/XOR/NOT, fetches operands from the register file (with writeback bypass), and stalls on register hazards via a scoreboard.
- Presents a registered opcode/operand_1/operand_2/rd bundle to the logical unit over a valid/ready handshake.

Parameters:
- WORD_SIZE, 19, datapath and instruction width
- NUM_REGS, 16, architectural registers
- REG_ADDR_W, 4, register index width (log2 NUM_REGS)
- OPCODE_W, 5, opcode field width
- STALL_CNT_W, 16, stall performance counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction valid
- in_ready  out  1  stage can accept instruction
- in_instr  in  WORD_SIZE  instruction: [18:14] opcode, [13:10] rd, [9:6] rs1, [5:2] rs2, [1:0] reserved
- rf_raddr1  out  REG_ADDR_W  regfile read address 1, combinational = in_instr[9:6]
- rf_rdata1  in  WORD_SIZE  regfile read data 1, combinational
- rf_raddr2  out  REG_ADDR_W  regfile read address 2, combinational = in_instr[5:2]
- rf_rdata2  in  WORD_SIZE  regfile read data 2
- wb_valid  in  1  writeback of a logical result this cycle
- wb_rd  in  REG_ADDR_W  writeback destination
- wb_data  in  WORD_SIZE  writeback data
- out_valid  out  1  issued bundle valid
- out_ready  in  1  logical unit accepts bundle
- out_opcode  out  OPCODE_W  decoded opcode
- out_operand_1  out  WORD_SIZE  operand 1
- out_operand_2  out  WORD_SIZE  operand 2 (0 for NOT)
- out_rd  out  REG_ADDR_W  destination register
- illegal_op  out  1  one-cycle pulse, non-logical opcode dropped
- stall_count  out  STALL_CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0; out_opcode/operands/out_rd=0.
  - illegal_op=0, stall_count=0, all scoreboard busy bits=0.
  - Reset mid-operation discards the held bundle and all pending bits.
- Decode:
  - Legal opcodes are OP_AND=5'h08, OP_OR=5'h09, OP_XOR=5'h0A, OP_NOT=5'h0B.
  - NOT uses rs1 only; rs2 is ignored for hazards and out_operand_2=0.
- Bypass:
  - When wb_valid and wb_rd equals a source register, the operand takes wb_data instead of rf_rdata, and that register counts as not busy this cycle.
- Hazard:
  - Legal op stalls if busy[rs1], busy[rs2] (non-NOT only) or busy[rd] (WAW), each after bypass clearing.
  - Non-logical opcodes never stall.
- Handshakes:
  - in_ready = (~out_valid | out_ready) & ~hazard. It depends only on the current cycle's in_instr when in_valid=1; when in_valid=0, hazard=0.
  - in_fire = in_valid & in_ready.
- Legal in_fire:
  - Output registers load next edge, out_valid=1, busy[rd] set.
  - Latency: one cycle from fire to out_valid.
- Illegal in_fire:
  - Instruction consumed; illegal_op=1 for exactly the next cycle.
  - out_valid and scoreboard unchanged, except out_valid clears if out_ready drained the held bundle.
- Output register:
  - When out_valid & out_ready with no new legal fire, out_valid goes 0 next edge.
  - Fire and drain in the same cycle gives back-to-back issue with no bubble.
  - While out_valid & ~out_ready, outputs hold stable.
- Scoreboard:
  - wb_valid clears busy[wb_rd].
  - Same-cycle set and clear on the same index: set wins.
  - Writeback to a non-busy register is ignored.
- stall_count: increments each cycle with in_valid & hazard; saturates at all-ones.
- Output register state (two states):
  - EMPTY (out_valid=0) to FULL on legal fire.
  - FULL to EMPTY on drain without legal fire.
  - FULL to FULL on hold, or on drain plus fire.

Decomposition:
- Package constants: WORD_SIZE, REG_ADDR_W, OPCODE_W, and instruction field bit positions.
- Package opcodes: opcode enum holding OP_AND/OP_OR/OP_XOR/OP_NOT values.
- Sub-module reg_scoreboard:
  - Holds the NUM_REGS busy vector.
  - Set port: issue rd.
  - Clear port: wb_rd.
  - Two source-check outputs plus a WAW check, all bypass-aware.

Test Plan:
- Reset then AND r3=r1&r2 with rf_rdata1=19'h7_0F0F, rf_rdata2=19'h0_FFFF, out_ready=1 -> next cycle out_valid=1, out_opcode=5'h08, operands 19'h7_0F0F/19'h0_FFFF, out_rd=3, busy[3]=1.
- RAW: issue XOR r4=r3^r1 while busy[3] -> in_ready=0, stall_count increments each cycle; assert wb_valid, wb_rd=3, wb_data=19'h1_2345 -> same-cycle fire with out_operand_1=19'h1_2345.
- Backpressure: out_ready=0 for 3 cycles with a held OR bundle -> outputs stable, in_ready=0; then out_ready=1 with a new legal instruction -> back-to-back issue, no bubble.
- Illegal opcode 5'h01 -> in_ready=1, consumed, illegal_op pulses exactly 1 cycle, busy unchanged, out_valid unchanged.
- NOT r5=~r5 with busy[6] set and rs2 field=6 -> no stall, out_operand_2=0; WAW: second write to r5 stalls until wb_rd=5.
- Assert rst_n low with out_valid=1 and busy bits set -> immediately out_valid=0, busy=0, stall_count=0; first post-reset instruction issues normally.
